// File: rtl/button_debouncer_if.sv
// Signal bundle between the push-button debouncer and its consumer.
// The event pulses are named release_pulse/repeat_pulse because "release" and "repeat" are reserved words.
interface button_debouncer_if;
    logic button_in;
    logic pressed;
    logic press;
    logic release_pulse;
    logic long_press;
    logic repeat_pulse;

    modport master (
        input  button_in,
        output pressed, press, release_pulse, long_press, repeat_pulse
    );

    modport slave (
        output button_in,
        input  pressed, press, release_pulse, long_press, repeat_pulse
    );
endinterface

// File: rtl/button_debouncer.sv
// Push-button input stage: synchronizer, bounce filter and registered
// press/release/long-press/auto-repeat events plus a debounced level.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,  // >= 1
    parameter int unsigned LONG_CYCLES     = 50_000_000, // >= 1
    parameter int unsigned REPEAT_CYCLES   = 10_000_000, // 0 disables repeat
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    button_debouncer_if.master btn
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    localparam logic [31:0] DEB_C      = 32'(DEBOUNCE_CYCLES);
    localparam logic [31:0] LONG_C     = 32'(LONG_CYCLES);
    localparam logic [31:0] REP_C      = 32'(REPEAT_CYCLES);
    localparam logic [31:0] REP_LAST_C = LONG_C + REP_C - 32'd1;

    state_t      state, state_next;
    logic        sync1, sync2, s;
    logic [31:0] dcnt, dcnt_next, dcnt_run;
    logic [31:0] hcnt, hcnt_next, hcnt_inc;
    logic        pressed_next, press_next, release_next, long_next, repeat_next;

    assign s        = sync2 ^ ACTIVE_LOW;
    assign dcnt_run = dcnt + 32'd1;
    assign hcnt_inc = hcnt + 32'd1;
    assign pressed_next = (state_next == HELD) || (state_next == RELEASE_WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1             <= ACTIVE_LOW;
            sync2             <= ACTIVE_LOW;
            state             <= IDLE;
            dcnt              <= '0;
            hcnt              <= '0;
            btn.pressed       <= 1'b0;
            btn.press         <= 1'b0;
            btn.release_pulse <= 1'b0;
            btn.long_press    <= 1'b0;
            btn.repeat_pulse  <= 1'b0;
        end else begin
            sync1             <= btn.button_in;
            sync2             <= sync1;
            state             <= state_next;
            dcnt              <= dcnt_next;
            hcnt              <= hcnt_next;
            btn.pressed       <= pressed_next;
            btn.press         <= press_next;
            btn.release_pulse <= release_next;
            btn.long_press    <= long_next;
            btn.repeat_pulse  <= repeat_next;
        end
    end

    // A change is accepted on its DEBOUNCE_CYCLES-th consecutive sample:
    // dcnt holds the samples already seen, so dcnt + 1 is the current run length.
    always_comb begin
        state_next   = state;
        dcnt_next    = dcnt;
        hcnt_next    = hcnt;
        press_next   = 1'b0;
        release_next = 1'b0;
        long_next    = 1'b0;
        repeat_next  = 1'b0;
        case (state)
            IDLE: begin
                if (s) begin
                    if (DEB_C <= 32'd1) begin
                        state_next = HELD;
                        press_next = 1'b1;
                        hcnt_next  = '0;
                    end else begin
                        state_next = PRESS_WAIT;
                        dcnt_next  = 32'd1;
                    end
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_next = IDLE;
                end else if (dcnt_run >= DEB_C) begin
                    state_next = HELD;
                    press_next = 1'b1;
                    hcnt_next  = '0;
                end else begin
                    dcnt_next = dcnt_run;
                end
            end
            HELD: begin
                if (!s && DEB_C <= 32'd1) begin
                    state_next   = IDLE;
                    release_next = 1'b1;
                    hcnt_next    = '0;
                end else begin
                    if (!s) begin
                        state_next = RELEASE_WAIT;
                        dcnt_next  = 32'd1;
                    end
                    // After long_press the counter wraps back to LONG_CYCLES each repeat period.
                    if (hcnt_inc == LONG_C) begin
                        long_next = 1'b1;
                        hcnt_next = hcnt_inc;
                    end else if (hcnt >= LONG_C) begin
                        if (REP_C == 32'd0) begin
                            hcnt_next = hcnt;
                        end else if (hcnt == REP_LAST_C) begin
                            repeat_next = 1'b1;
                            hcnt_next   = LONG_C;
                        end else begin
                            hcnt_next = hcnt_inc;
                        end
                    end else begin
                        hcnt_next = hcnt_inc;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_next = HELD;
                end else if (dcnt_run >= DEB_C) begin
                    state_next   = IDLE;
                    release_next = 1'b1;
                    hcnt_next    = '0;
                end else begin
                    dcnt_next = dcnt_run;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE=4, LONG=20, REPEAT=8,
// one active-high instance and one active-low instance.
module tb_button_debouncer;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    button_debouncer_if ifa ();
    button_debouncer_if ifb ();

    button_debouncer #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES(20),
        .REPEAT_CYCLES(8),
        .ACTIVE_LOW(1'b0)
    ) dut_hi (
        .clk(clk),
        .reset(reset),
        .btn(ifa)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES(20),
        .REPEAT_CYCLES(8),
        .ACTIVE_LOW(1'b1)
    ) dut_lo (
        .clk(clk),
        .reset(reset),
        .btn(ifb)
    );

    always #5 clk = ~clk;

    // {pressed, press, release, long_press, repeat}
    logic [4:0] obs_a, obs_b;
    assign obs_a = {ifa.pressed, ifa.press, ifa.release_pulse, ifa.long_press, ifa.repeat_pulse};
    assign obs_b = {ifb.pressed, ifb.press, ifb.release_pulse, ifb.long_press, ifb.repeat_pulse};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ifa.button_in = 1'b0;
        ifb.button_in = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (obs_a !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_hi: got %b want 00000 (pressed,press,release,long,repeat)", obs_a);
        end
        n_checks++;
        if (obs_b !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_lo: got %b want 00000 (pressed,press,release,long,repeat)", obs_b);
        end
    endtask

    task automatic test_clean_press();
        logic [4:0] exp;
        do_reset();
        ifa.button_in = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            exp = {k >= 5, k == 5, 1'b0, k == 25, k == 33};
            n_checks++;
            if (obs_a !== exp) begin
                n_fail++;
                $display("FAIL clean_press edge %0d: got %b want %b", k, obs_a, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] pattern;
        pattern = 8'b0011_0111; // LSB first: 1,1,1,0,1,1,0,0
        do_reset();
        for (int k = 0; k < 16; k++) begin
            ifa.button_in = (k < 8) ? pattern[k] : 1'b0;
            tick();
            n_checks++;
            if (obs_a !== 5'b00000) begin
                n_fail++;
                $display("FAIL bounce edge %0d: got %b want 00000", k, obs_a);
            end
        end
    endtask

    task automatic test_release_glitch();
        logic [4:0] exp;
        do_reset();
        for (int k = 0; k < 32; k++) begin
            ifa.button_in = (k == 10 || k == 11) ? 1'b0 : 1'b1;
            tick();
            exp = {k >= 5, k == 5, 1'b0, k == 27, 1'b0};
            n_checks++;
            if (obs_a !== exp) begin
                n_fail++;
                $display("FAIL release_glitch edge %0d: got %b want %b", k, obs_a, exp);
            end
        end
    endtask

    task automatic test_long_hold();
        logic [4:0] exp;
        logic       rep;
        do_reset();
        for (int k = 0; k < 76; k++) begin
            ifa.button_in = (k <= 65) ? 1'b1 : 1'b0;
            tick();
            rep = (k == 33) || (k == 41) || (k == 49) || (k == 57) || (k == 65);
            exp = {k >= 5 && k < 71, k == 5, k == 71, k == 25, rep};
            n_checks++;
            if (obs_a !== exp) begin
                n_fail++;
                $display("FAIL long_hold edge %0d: got %b want %b", k, obs_a, exp);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [4:0] exp;
        do_reset();
        ifa.button_in = 1'b1;
        for (int k = 0; k <= 10; k++) tick();
        n_checks++;
        if (ifa.pressed !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_hold_pre: pressed got %b want 1", ifa.pressed);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (obs_a !== 5'b00000) begin
            n_fail++;
            $display("FAIL mid_hold_reset: got %b want 00000", obs_a);
        end
        for (int j = 1; j <= 12; j++) begin
            tick();
            exp = {j >= 6, j == 6, 1'b0, 1'b0, 1'b0};
            n_checks++;
            if (obs_a !== exp) begin
                n_fail++;
                $display("FAIL mid_hold_after edge +%0d: got %b want %b", j, obs_a, exp);
            end
        end
    endtask

    task automatic test_polarity();
        logic [4:0] exp;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            tick();
            n_checks++;
            if (obs_b !== 5'b00000) begin
                n_fail++;
                $display("FAIL polarity_idle edge %0d: got %b want 00000", k, obs_b);
            end
        end
        ifb.button_in = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            exp = {k >= 5, k == 5, 1'b0, 1'b0, 1'b0};
            n_checks++;
            if (obs_b !== exp) begin
                n_fail++;
                $display("FAIL polarity_press edge %0d: got %b want %b", k, obs_b, exp);
            end
        end
    endtask

    initial begin
        ifa.button_in = 1'b0;
        ifb.button_in = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_glitch();
        test_long_hold();
        test_reset_mid_hold();
        test_polarity();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
